// File: rtl/sweep_counter_ctrl.sv
// sweep_counter_ctrl: drives an up/down counter through N triangle sweeps
// between a latched low and high bound. The counter value is read back to
// decide where to turn around, and a count outside the window ends the run
// with an error pulse. A start/done handshake faces the host.
module sweep_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int NSW_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,          // synchronous, active-high
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NSW_W-1:0] n_sweeps,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_ena,
    output logic             cnt_set,
    output logic [WIDTH-1:0] cnt_set_value,
    output logic             cnt_up_down,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NSW_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [NSW_W-1:0] n_q;

    // Turnaround points; lo_q < hi_q for any accepted run, so neither wraps.
    logic [WIDTH-1:0] hi_m1, lo_p1;
    assign hi_m1 = hi_q - WIDTH'(1);
    assign lo_p1 = lo_q + WIDTH'(1);

    logic req_ok, accept, reject, in_run, out_of_win, win_err;
    logic sweep_end, sweep_step, last_sweep;

    assign req_ok     = (lo < hi) && (n_sweeps != '0);
    assign accept     = (state == IDLE) && start && !abort && req_ok;
    assign reject     = (state == IDLE) && start && !abort && !req_ok;
    assign in_run     = (state == UP) || (state == DOWN);
    assign out_of_win = (count_in < lo_q) || (count_in > hi_q);
    // Abort wins over a window violation: an aborted run never reports err.
    assign win_err    = in_run && !abort && out_of_win;
    assign sweep_end  = (state == DOWN) && (count_in == lo_p1);
    assign sweep_step = sweep_end && !abort && !out_of_win;
    assign last_sweep = (sweep_cnt + NSW_W'(1)) == n_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples
        // pre-edge values regardless of process evaluation order.
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt
        // unassigned and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: state_nxt = abort ? IDLE : UP;
            UP: begin
                if (abort || out_of_win)  state_nxt = IDLE;
                else if (count_in == hi_m1) state_nxt = DOWN;
            end
            DOWN: begin
                if (abort || out_of_win) state_nxt = IDLE;
                else if (sweep_end)      state_nxt = last_sweep ? DONE : UP;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bounds, sweep count and the registered error pulse.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= '0;
            sweep_cnt <= '0;
            err       <= 1'b0;
        end else begin
            err <= reject || win_err;
            if (accept) begin
                lo_q      <= lo;
                hi_q      <= hi;
                n_q       <= n_sweeps;
                sweep_cnt <= '0;
            end else if (sweep_step) begin
                sweep_cnt <= sweep_cnt + NSW_W'(1);
            end
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        cnt_ena       = 1'b0;
        cnt_set       = 1'b0;
        cnt_set_value = '0;
        cnt_up_down   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            LOAD: begin
                cnt_set       = 1'b1;
                cnt_set_value = lo_q;
                busy          = 1'b1;
            end
            UP: begin
                cnt_ena     = 1'b1;
                cnt_up_down = 1'b1;
                busy        = 1'b1;
            end
            DOWN: begin
                cnt_ena = 1'b1;
                busy    = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Bench for sweep_counter_ctrl: a behavioural up/down counter closes the
// loop, stimulus pushes expected done/err events into a queue, and a monitor
// pops and compares them whenever the DUT raises done or err.
module tb_sweep_counter_ctrl;

    localparam int WIDTH = 4;
    localparam int NSW_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] lo = '0, hi = '0;
    logic [NSW_W-1:0] n_sweeps = '0;
    logic [WIDTH-1:0] count_in;
    logic             cnt_ena, cnt_set, cnt_up_down, busy, done, err;
    logic [WIDTH-1:0] cnt_set_value;
    logic [NSW_W-1:0] sweep_cnt;

    sweep_counter_ctrl #(.WIDTH(WIDTH), .NSW_W(NSW_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .count_in(count_in),
        .cnt_ena(cnt_ena), .cnt_set(cnt_set), .cnt_set_value(cnt_set_value),
        .cnt_up_down(cnt_up_down), .busy(busy), .done(done), .err(err),
        .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The controlled counter, with an override used to push it out of window.
    logic [WIDTH-1:0] cnt_q = '0;
    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = '0;
    always @(posedge clk) begin
        if (cnt_set)      cnt_q <= cnt_set_value;
        else if (cnt_ena) cnt_q <= cnt_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
    assign count_in = force_en ? force_val : cnt_q;

    typedef struct {
        bit is_done;
        int cycle;
        int swc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_sweep = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done || err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, done, err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_done", int'(done), int'(mon_e.is_done));
                check("event_err", int'(err), int'(!mon_e.is_done));
                check("event_cycle", cyc, mon_e.cycle);
                if (mon_e.is_done) begin
                    check("done_sweep_cnt", int'(sweep_cnt), mon_e.swc);
                    check("done_count", int'(count_in), mon_e.cnt);
                    check("done_busy", int'(busy), 0);
                end
            end
        end
    end

    // Expected counter value at position p of the active (UP/DOWN) cycles of
    // a run: a triangle lo..hi..lo with period 2*(hi-lo).
    function automatic int tri_val(input int l, input int h, input int p);
        int d, k;
        d = h - l;
        k = p % (2 * d);
        return (k <= d) ? l + k : l + 2 * d - k;
    endfunction

    // Issue one start request and follow it to completion.
    task automatic run(input int l, input int h, input int n, input bit extra_start);
        int  accept, i, p, prev_dir;
        bit  valid, pulsed;
        valid = (l < h) && (n != 0);
        @(negedge clk);
        lo = WIDTH'(l); hi = WIDTH'(h); n_sweeps = NSW_W'(n); start = 1'b1;
        accept = cyc + 1;
        if (valid) begin
            exp_q.push_back('{1'b1, accept + 1 + n * 2 * (h - l), n, l});
            exp_sweep = n;
        end else begin
            exp_q.push_back('{1'b0, accept, exp_sweep, 0});
        end
        @(negedge clk);
        start = 1'b0;
        // Scramble the request inputs: only the latched copies may matter.
        lo = WIDTH'($urandom); hi = WIDTH'($urandom); n_sweeps = NSW_W'($urandom);
        if (!valid) begin
            check("reject_busy", int'(busy), 0);
            check("reject_cnt_set", int'(cnt_set), 0);
            check("reject_sweep_cnt", int'(sweep_cnt), exp_sweep);
            return;
        end
        check("load_cnt_set", int'(cnt_set), 1);
        check("load_value", int'(cnt_set_value), l);
        i = 0; p = 0; pulsed = 0; prev_dir = -1;
        while (busy && i < 600) begin
            @(negedge clk);
            i++;
            start = 1'b0;
            if (cnt_ena) begin
                check("count_seq", int'(count_in), tri_val(l, h, p));
                if (h == l + 1 && prev_dir >= 0)
                    check("min_window_toggle", int'(cnt_up_down), 1 - prev_dir);
                prev_dir = int'(cnt_up_down);
                p++;
                if (extra_start && !cnt_up_down && !pulsed) begin
                    start = 1'b1;
                    pulsed = 1;
                end
            end
        end
        start = 1'b0;
        check("run_timeout", int'(i < 600), 1);
        check("active_cycles", p, n * 2 * (h - l));
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_cnt_ena", int'(cnt_ena), 0);
    endtask

    // Start a run, then abort (or reset) it when the counter reaches stop_val
    // within sweep stop_sweep.
    task automatic cut_run(input int l, input int h, input int n, input int stop_val,
                           input int stop_sweep, input bit use_reset);
        int i;
        @(negedge clk);
        lo = WIDTH'(l); hi = WIDTH'(h); n_sweeps = NSW_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (!(cnt_ena && int'(count_in) == stop_val && int'(sweep_cnt) == stop_sweep)
               && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("cut_wait_timeout", int'(i < 300), 1);
        if (use_reset) rst_n = 1'b1;
        else           abort = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        abort = 1'b0;
        exp_sweep = use_reset ? 0 : stop_sweep;
        check("cut_busy", int'(busy), 0);
        check("cut_cnt_ena", int'(cnt_ena), 0);
        check("cut_done", int'(done), 0);
        check("cut_sweep_cnt", int'(sweep_cnt), exp_sweep);
        repeat (3) @(negedge clk);
        check("cut_still_idle", int'(busy), 0);
    endtask

    // Force the counter out of window during UP; the run must end with err.
    task automatic window_run(input int l, input int h, input int bad);
        int i;
        @(negedge clk);
        lo = WIDTH'(l); hi = WIDTH'(h); n_sweeps = NSW_W'(1); start = 1'b1;
        exp_sweep = 0;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (!(cnt_ena && cnt_up_down && int'(count_in) == l + 1) && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("win_wait_timeout", int'(i < 100), 1);
        force_en = 1'b1;
        force_val = WIDTH'(bad);
        exp_q.push_back('{1'b0, cyc + 1, 0, 0});
        @(negedge clk);
        force_en = 1'b0;
        check("win_busy", int'(busy), 0);
        check("win_cnt_ena", int'(cnt_ena), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int l, h, n;
        // Reset held for two edges.
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outputs",
              int'({cnt_ena, cnt_set, cnt_up_down, busy, done, err}), 0);
        check("rst_set_value", int'(cnt_set_value), 0);
        check("rst_sweep_cnt", int'(sweep_cnt), 0);
        rst_n = 1'b0;
        @(negedge clk);

        run(2, 5, 2, 0);
        run(7, 8, 3, 0);
        run(5, 5, 2, 0);
        run(3, 9, 0, 0);
        run(9, 4, 1, 0);
        cut_run(0, 15, 1, 9, 0, 0);
        cut_run(1, 4, 3, 3, 1, 0);
        cut_run(0, 15, 1, 9, 0, 1);
        window_run(3, 6, 12);
        run(3, 6, 1, 1);
        run(0, 15, 1, 0);

        for (int k = 0; k < 25; k++) begin
            l = $urandom_range(0, 15);
            h = $urandom_range(0, 15);
            n = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0 && l > h) begin
                int t;
                t = l; l = h; h = t;
            end
            run(l, h, n, bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
